// File: rtl/clk_edge_monitor_pkg.sv
// clk_mon_pkg: shared types and default sizing for the clock edge monitor.
package clk_mon_pkg;

  localparam int unsigned PW_DEFAULT      = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 64;
  localparam int unsigned DG_LEN_DEFAULT  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    MEAS  = 2'd2,
    STALL = 2'd3
  } mon_state_t;

endpackage

// File: rtl/clk_edge_monitor_if.sv
// clk_edge_monitor_if: monitored clock input, enable and the measurement
// results. The master side drives clk_in/en, the slave side is the monitor.
interface clk_edge_monitor_if
  import clk_mon_pkg::*;
#(
  parameter int unsigned PW = PW_DEFAULT
);

  logic          clk_in;
  logic          en;
  logic          tick;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;
  logic [31:0]   edge_count;

  modport master (
    output clk_in, en,
    input  tick, period, period_valid, stalled, edge_count
  );

  modport slave (
    input  clk_in, en,
    output tick, period, period_valid, stalled, edge_count
  );

endinterface

// File: rtl/clk_edge_monitor_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for asynchronous inputs (clocks
// sampled as data, switches, buttons). Both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two back-to-back flops give metastability time before q is used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: samples a slow clock as data in the clk domain, emits a
// one-cycle rising-edge tick, measures the edge-to-edge period in clk cycles
// and flags a clock that has stopped toggling.
// Build option: define CLK_MON_DEGLITCH_EN to insert a stability filter of
// DG_LEN cycles between the synchronizer and the edge detector.
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned PW      = PW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned DG_LEN  = DG_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  clk_edge_monitor_if.slave bus
);

  // Reject configurations where the timeout cannot be represented in cnt
  if (TIMEOUT < 2 || 64'(TIMEOUT) >= (64'd1 << PW) || DG_LEN < 1) begin : g_bad_cfg
    $error("clk_edge_monitor: TIMEOUT or DG_LEN out of range");
  end

  logic          s2;
  logic          lvl;
  logic          lvl_d;
  logic          rise;
  mon_state_t    state;
  logic [PW-1:0] cnt;
  logic          tick_q;
  logic [PW-1:0] period_q;
  logic          period_valid_q;
  logic          stalled_q;
  logic [31:0]   edge_count_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.clk_in),
    .q   (s2)
  );

`ifdef CLK_MON_DEGLITCH_EN
  localparam int unsigned DG_W = (DG_LEN > 1) ? $clog2(DG_LEN + 1) : 1;

  logic [DG_W-1:0] dg_cnt;

  // Level follows s2 only after s2 has disagreed with it for DG_LEN cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl    <= 1'b0;
      dg_cnt <= '0;
    end else if (s2 == lvl) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DG_LEN - 1)) begin
      lvl    <= s2;
      dg_cnt <= '0;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end
`else
  // Without the filter the level is just one more register after the synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= 1'b0;
    end else begin
      lvl <= s2;
    end
  end
`endif

  // Previous level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;

  // Measurement FSM with all outputs registered; en low forces IDLE from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      tick_q         <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      tick_q         <= rise & bus.en;
      period_valid_q <= 1'b0;
      if (rise && bus.en) begin
        edge_count_q <= edge_count_q + 1'b1;
      end
      if (!bus.en) begin
        state     <= IDLE;
        cnt       <= '0;
        stalled_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT;
            cnt   <= '0;
          end
          WAIT: begin
            cnt <= '0;
            if (rise) begin
              state <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period_q       <= cnt + 1'b1;
              period_valid_q <= 1'b1;
              cnt            <= '0;
            end else if (cnt == PW'(TIMEOUT - 1)) begin
              state     <= STALL;
              stalled_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STALL: begin
            if (rise) begin
              state     <= MEAS;
              cnt       <= '0;
              stalled_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.stalled      = stalled_q;
  assign bus.edge_count   = edge_count_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor: scoreboard bench for clk_edge_monitor. The stimulus
// side drives clk_in/en and a behavioural model pushes the expected tick and
// stalled events (with the cycle they must appear in) into queues; a monitor
// pops and compares whenever the DUT presents a tick or a stalled change.
// Honours CLK_MON_DEGLITCH_EN the same way the design does.
module tb_clk_edge_monitor;

  localparam int unsigned PW      = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DG_LEN  = 3;

  typedef struct {
    int          cyc;
    logic        pv;
    logic [PW-1:0] period;
    logic [31:0] count;
  } tick_exp_t;

  typedef struct {
    int   cyc;
    logic val;
  } stall_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  clk_edge_monitor_if #(.PW(PW)) bus ();

  clk_edge_monitor #(
    .PW      (PW),
    .TIMEOUT (TIMEOUT),
    .DG_LEN  (DG_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock and a free-running cycle index used to time expectations
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_exp_t  tick_q[$];
  stall_exp_t stall_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ticks_seen = 0;

  // Reference model state: input history, filtered level, measurement bookkeeping
  logic [15:0]   hist;
  logic          m_lvl, m_lvl_d;
  logic          m_prev_en, m_armed, m_stalled;
  int            m_last;
  logic [PW-1:0] m_period;
  logic [31:0]   m_count;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic model_reset();
    hist      = '0;
    m_lvl     = 1'b0;
    m_lvl_d   = 1'b0;
    m_prev_en = 1'b0;
    m_armed   = 1'b0;
    m_stalled = 1'b0;
    m_last    = 0;
    m_period  = '0;
    m_count   = '0;
    tick_q.delete();
    stall_q.delete();
  endtask

  // One clk cycle of the model: input reaches the edge detector 3 cycles later
  task automatic model_step(input logic ci, input logic e);
    logic       s2, rise, nxt;
    int         gap;
    tick_exp_t  te;
    stall_exp_t se;
`ifdef CLK_MON_DEGLITCH_EN
    logic steady;
`endif
    hist = {hist[14:0], ci};
    s2   = hist[2];
    rise = m_lvl & ~m_lvl_d;
`ifdef CLK_MON_DEGLITCH_EN
    nxt    = m_lvl;
    steady = 1'b1;
    for (int k = 0; k < int'(DG_LEN); k++) begin
      if (hist[2+k] != s2) steady = 1'b0;
    end
    if (steady) nxt = s2;
`else
    nxt = s2;
`endif
    m_lvl_d = m_lvl;
    m_lvl   = nxt;
    if (e) begin
      if (rise) begin
        gap = cyc - m_last;
        m_count++;
        te.pv = m_prev_en && m_armed && !m_stalled;
        if (te.pv) m_period = PW'(gap);
        if (m_prev_en) begin
          if (m_stalled) begin
            m_stalled = 1'b0;
            se.cyc = cyc + 1;
            se.val = 1'b0;
            stall_q.push_back(se);
          end
          m_armed = 1'b1;
          m_last  = cyc;
        end
        te.cyc    = cyc + 1;
        te.period = m_period;
        te.count  = m_count;
        tick_q.push_back(te);
      end else if (m_prev_en && m_armed && !m_stalled && (cyc - m_last) == int'(TIMEOUT)) begin
        m_stalled = 1'b1;
        se.cyc = cyc + 1;
        se.val = 1'b1;
        stall_q.push_back(se);
      end
    end else begin
      m_armed = 1'b0;
      if (m_stalled) begin
        m_stalled = 1'b0;
        se.cyc = cyc + 1;
        se.val = 1'b0;
        stall_q.push_back(se);
      end
    end
    m_prev_en = e;
  endtask

  task automatic apply_stimulus(input logic ci, input logic e);
    @(posedge clk);
    #1;
    if (bus.tick === 1'b1) ticks_seen++;
    bus.clk_in = ci;
    bus.en     = e;
    model_step(ci, e);
  endtask

  task automatic run_div(input int half, input int n_periods, input logic e);
    for (int p = 0; p < n_periods; p++) begin
      for (int i = 0; i < half; i++) apply_stimulus(1'b1, e);
      for (int i = 0; i < half; i++) apply_stimulus(1'b0, e);
    end
  endtask

  task automatic release_reset(input logic e);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.clk_in = 1'b0;
    bus.en     = e;
    model_step(1'b0, e);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_tick"}, 32'(bus.tick), 32'd0);
    check_output({tag, "_period"}, 32'(bus.period), 32'd0);
    check_output({tag, "_period_valid"}, 32'(bus.period_valid), 32'd0);
    check_output({tag, "_stalled"}, 32'(bus.stalled), 32'd0);
    check_output({tag, "_edge_count"}, bus.edge_count, 32'd0);
  endtask

  // Monitor: consume expectations whenever the DUT presents a tick or a stalled change
  logic prev_st = 1'b0;
  always @(negedge clk) begin
    tick_exp_t  te;
    stall_exp_t se;
    if (rst !== 1'b1) begin
      while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
        te = tick_q.pop_front();
        n_checks++;
        n_fail++;
        $display("[TB] FAIL tick_missing: no tick, expected one in cycle %0d (now %0d)", te.cyc, cyc);
      end
      while (stall_q.size() > 0 && stall_q[0].cyc < cyc) begin
        se = stall_q.pop_front();
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stalled_missing: stalled stayed %0d, expected %0d in cycle %0d", bus.stalled, se.val, se.cyc);
      end
      if (bus.tick === 1'b1) begin
        if (tick_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL tick_unexpected: tick=1, expected 0 (cycle %0d)", cyc);
        end else begin
          te = tick_q.pop_front();
          check_output("tick_cycle", 32'(cyc), 32'(te.cyc));
          check_output("period_valid", 32'(bus.period_valid), 32'(te.pv));
          check_output("period", 32'(bus.period), 32'(te.period));
          check_output("edge_count", bus.edge_count, te.count);
        end
      end else if (bus.period_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL pv_without_tick: period_valid=%0d, expected 0 (cycle %0d)", bus.period_valid, cyc);
      end
      if (bus.stalled !== prev_st) begin
        if (stall_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL stalled_unexpected: stalled=%0d, expected %0d (cycle %0d)", bus.stalled, prev_st, cyc);
        end else begin
          se = stall_q.pop_front();
          check_output("stalled_cycle", 32'(cyc), 32'(se.cyc));
          check_output("stalled_value", 32'(bus.stalled), 32'(se.val));
        end
      end
    end
    prev_st = bus.stalled;
  end

  initial begin
    logic [PW-1:0] held_period;
    logic [31:0]   held_count;
    rst        = 1'b1;
    bus.clk_in = 1'b0;
    bus.en     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset(1'b1);

    $display("[TB] clk/8 with en=1");
    run_div(4, 12, 1'b1);
    check_output("period_div8", 32'(bus.period), 32'd8);

    $display("[TB] clk/2");
    run_div(1, 20, 1'b1);
    check_output("period_div2", 32'(bus.period), 32'd2);
    check_output("stalled_div2", 32'(bus.stalled), 32'd0);

    $display("[TB] stop clk_in, then restart");
    run_div(4, 4, 1'b1);
    for (int i = 0; i < 80; i++) apply_stimulus(1'b0, 1'b1);
    check_output("stalled_after_stop", 32'(bus.stalled), 32'd1);
    run_div(4, 3, 1'b1);
    check_output("stalled_cleared", 32'(bus.stalled), 32'd0);
    check_output("period_after_restart", 32'(bus.period), 32'd8);

    $display("[TB] disable mid-measurement");
    run_div(4, 4, 1'b1);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1);
    held_period = m_period;
    held_count  = m_count;
    run_div(4, 3, 1'b0);
    check_output("hold_period", 32'(bus.period), 32'(held_period));
    check_output("hold_edge_count", bus.edge_count, held_count);
    check_output("disabled_tick", 32'(bus.tick), 32'd0);
    run_div(4, 4, 1'b1);

    $display("[TB] randomized clk_in and en");
    for (int blk = 0; blk < 40; blk++) begin
      int   hi, lo;
      logic e;
      hi = int'($urandom_range(1, 12));
      lo = int'($urandom_range(1, 70));
      e  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < hi; i++) apply_stimulus(1'b1, e);
      for (int i = 0; i < lo; i++) apply_stimulus(1'b0, e);
    end

    $display("[TB] single-cycle glitch");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    ticks_seen = 0;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1);
`ifdef CLK_MON_DEGLITCH_EN
    check_output("glitch_ticks", 32'(ticks_seen), 32'd0);
`else
    check_output("glitch_ticks", 32'(ticks_seen), 32'd1);
`endif

    $display("[TB] asynchronous reset between edges");
    run_div(4, 3, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    release_reset(1'b1);
    run_div(4, 4, 1'b1);
    check_output("period_after_reset", 32'(bus.period), 32'd8);

    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_output("tick_queue_empty", 32'(tick_q.size()), 32'd0);
    check_output("stall_queue_empty", 32'(stall_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
